// File: rtl/cla_share_arb_pkg.sv
// Shared definitions for every backend user of the shared-adder arbiter:
// requester IDs, the default requester count and the ID-width helper.
package cla_share_arb_pkg;

  localparam int unsigned NREQ_DEFAULT = 3;

  localparam int unsigned REQ_AGU = 0;
  localparam int unsigned REQ_BR  = 1;
  localparam int unsigned REQ_PC  = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder: ripple inside a block, group generate/propagate
// between blocks. "hybird" uses 4-bit blocks, any other structure 2-bit blocks.
module cla_adder #(
  parameter int unsigned NUM = 32,
  parameter string       ST  = "hybird"
) (
  input  logic [NUM-1:0] a_i,
  input  logic [NUM-1:0] b_i,
  input  logic           cin_i,
  output logic [NUM-1:0] sum_o
);

  localparam int unsigned Blk = (ST == "hybird") ? 4 : 2;
  localparam int unsigned NB  = (NUM + Blk - 1) / Blk;

  logic [NUM-1:0] g, p, c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = cin_i;

  for (genvar bi = 0; bi < NB; bi++) begin : g_blk
    localparam int unsigned Lo = bi * Blk;
    localparam int unsigned Hi = (Lo + Blk > NUM) ? NUM : Lo + Blk;

    for (genvar j = Lo; j < Hi - 1; j++) begin : g_bit
      assign c[j+1] = g[j] | (p[j] & c[j]);
    end

    // Block carry-out skips the in-block chain; the final carry-out is discarded.
    if (Hi < NUM) begin : g_grp
      logic blk_g, blk_p;
      always_comb begin
        blk_g = 1'b0;
        for (int j = Lo; j < Hi; j++) blk_g = g[j] | (p[j] & blk_g);
      end
      assign blk_p = &p[Hi-1:Lo];
      assign c[Hi] = blk_g | (blk_p & c[Lo]);
    end
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping modulo N. Produces a one-hot grant plus its binary index.
module rr_arbiter
  import cla_share_arb_pkg::*;
#(
  parameter  int unsigned N   = NREQ_DEFAULT,
  localparam int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o
);

  logic           found;
  logic [IDW:0]   idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = {1'b0, ptr_i} + (IDW+1)'(k);
        if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
        if (!found && req_i[idx[IDW-1:0]]) begin
          found                  = 1'b1;
          gnt_o[idx[IDW-1:0]]    = 1'b1;
          gnt_id_o               = idx[IDW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/cla_share_arb.sv
// Shares one cla_adder between NREQ requesters: round-robin grant, one-entry
// registered response slot returned with the winner's ID over valid/ready.
module cla_share_arb
  import cla_share_arb_pkg::*;
#(
  parameter  int unsigned NUM  = 32,
  parameter  int unsigned NREQ = NREQ_DEFAULT,
  parameter  string       ST   = "hybird",
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*NUM-1:0] req_a_i,
  input  logic [NREQ*NUM-1:0] req_b_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [NUM-1:0]      rsp_sum_o,
  output logic [IDW-1:0]      rsp_id_o
);

  logic [IDW-1:0]  ptr_q, ptr_d, gnt_id;
  logic [NREQ-1:0] gnt;
  logic            slot_free, grant_en, hs;
  logic [NUM-1:0]  op_a, op_b, sum;
  logic            rsp_valid_q, rsp_valid_d;
  logic [NUM-1:0]  rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  assign slot_free = ~rsp_valid_q | rsp_ready_i;
  // Holding grants off during reset keeps requesters from seeing a phantom handshake.
  assign grant_en  = slot_free & ~rst_i;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .en_i     (grant_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_a = req_a_i[i*NUM +: NUM];
        op_b = req_b_i[i*NUM +: NUM];
      end
    end
  end

  cla_adder #(
    .NUM (NUM),
    .ST  (ST)
  ) u_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .cin_i (1'b0),
    .sum_o (sum)
  );

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    if (hs) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum;
      rsp_id_d    = gnt_id;
      ptr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_cla_share_arb.sv
// Self-checking bench for cla_share_arb: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbiter and response slot.
module tb_cla_share_arb;
  import cla_share_arb_pkg::*;

  localparam int unsigned NUM  = 32;
  localparam int unsigned NREQ = 3;
  localparam int unsigned IDW  = id_width(NREQ);

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [NREQ-1:0]     req_valid_i, req_ready_o;
  logic [NREQ*NUM-1:0] req_a_i, req_b_i;
  logic                rsp_valid_o, rsp_ready_i;
  logic [NUM-1:0]      rsp_sum_o;
  logic [IDW-1:0]      rsp_id_o;

  cla_share_arb #(
    .NUM  (NUM),
    .NREQ (NREQ),
    .ST   ("hybird")
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_id_o    (rsp_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester-side stimulus and the reference model of the response slot.
  bit          v_arr [NREQ];
  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];
  bit          rr;
  bit          m_valid;
  longint      m_sum;
  int          m_id;
  int          m_ptr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i]           = v_arr[i];
      req_a_i[i*NUM +: NUM]    = a_arr[i];
      req_b_i[i*NUM +: NUM]    = b_arr[i];
    end
    rsp_ready_i = rr;
  endtask

  function automatic int model_winner();
    if (m_valid && !rr) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v_arr[i]) return i;
    end
    return -1;
  endfunction

  // Called just after a falling edge; leaves just after the next falling edge.
  task automatic step(output logic [NREQ-1:0] rdy_obs);
    int w;
    logic [NREQ-1:0] rdy_exp;
    drive();
    #1;
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'(m_valid));
    if (m_valid) begin
      check_eq("rsp_sum", 64'(rsp_sum_o), 64'(m_sum));
      check_eq("rsp_id", 64'(rsp_id_o), 64'(m_id));
    end
    w       = model_winner();
    rdy_exp = (w >= 0) ? NREQ'(1) << w : '0;
    rdy_obs = req_ready_o;
    check_eq("req_ready", 64'(rdy_obs), 64'(rdy_exp));
    @(posedge clk_i);
    if (w >= 0) begin
      m_sum   = (longint'(a_arr[w]) + longint'(b_arr[w])) % (longint'(1) << NUM);
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % NREQ;
      v_arr[w] = 0;
    end else if (rr) begin
      m_valid = 0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) v_arr[i] = 1;
    drive();
    #2 rst_i = 1'b1;
    #1;
    check_eq("rst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_sum", 64'(rsp_sum_o), 64'd0);
    check_eq("rst_id", 64'(rsp_id_o), 64'd0);
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk_i);
    #1 check_eq("rst_ready_hold", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    m_valid = 0;
    m_sum   = 0;
    m_id    = 0;
    m_ptr   = 0;
    for (int i = 0; i < NREQ; i++) v_arr[i] = 0;
  endtask

  task automatic set_valid(input bit v0, input bit v1, input bit v2);
    v_arr[0] = v0;
    v_arr[1] = v1;
    v_arr[2] = v2;
  endtask

  initial begin
    logic [NREQ-1:0] rdy;
    logic [NUM-1:0]  held_sum;
    logic [IDW-1:0]  held_id;

    for (int i = 0; i < NREQ; i++) begin
      v_arr[i] = 0;
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    rr = 1;
    m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0;
    drive();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Single request from requester 1.
    set_valid(0, 1, 0);
    a_arr[1] = 32'h0000_0010; b_arr[1] = 32'h0000_0020;
    step(rdy);
    check_eq("single_ready", 64'(rdy), 64'b010);
    #1;
    check_eq("single_sum", 64'(rsp_sum_o), 64'h30);
    check_eq("single_id", 64'(rsp_id_o), 64'd1);

    // Modulo wrap, carry-out discarded.
    set_valid(1, 0, 0);
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h0000_0002;
    step(rdy);
    #1 check_eq("wrap_sum", 64'(rsp_sum_o), 64'h1);

    // Reset while a response (0x5) is pending.
    set_valid(1, 0, 0);
    a_arr[0] = 32'd2; b_arr[0] = 32'd3;
    step(rdy);
    #1 check_eq("pre_rst_sum", 64'(rsp_sum_o), 64'h5);
    do_reset();

    // Fairness from ptr=0 with all requesters busy.
    for (int k = 0; k < 6; k++) begin
      set_valid(1, 1, 1);
      for (int i = 0; i < NREQ; i++) begin a_arr[i] = 32'(i + 10 * k); b_arr[i] = 32'd100; end
      step(rdy);
      check_eq("fair_order", 64'(rdy), 64'(NREQ'(1) << (k % 3)));
      #1 check_eq("fair_nobubble", 64'(rsp_valid_o), 64'd1);
    end

    // Backpressure: slot full, consumer stalled.
    held_sum = rsp_sum_o;
    held_id  = rsp_id_o;
    rr = 0;
    for (int k = 0; k < 4; k++) begin
      set_valid(1, 1, 1);
      step(rdy);
      check_eq("bp_ready", 64'(rdy), 64'd0);
      #1;
      check_eq("bp_sum", 64'(rsp_sum_o), 64'(held_sum));
      check_eq("bp_id", 64'(rsp_id_o), 64'(held_id));
    end
    rr = 1;
    set_valid(1, 1, 1);
    step(rdy);
    check_eq("bp_release", 64'(rdy), 64'b001);
    #1 check_eq("bp_reload_valid", 64'(rsp_valid_o), 64'd1);

    // Sparse pointer behaviour.
    do_reset();
    set_valid(0, 1, 0);
    step(rdy);
    set_valid(1, 0, 0);
    step(rdy);
    check_eq("sparse_g0", 64'(rdy), 64'b001);
    set_valid(1, 0, 1);
    step(rdy);
    check_eq("sparse_g2", 64'(rdy), 64'b100);

    // Randomized traffic with occasional drops and resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v_arr[i] && ($urandom % 16 == 0)) v_arr[i] = 0;
        else if (!v_arr[i] && ($urandom % 2 == 0)) begin
          v_arr[i] = 1;
          a_arr[i] = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
          b_arr[i] = $urandom;
        end
      end
      rr = ($urandom % 4) != 0;
      if ($urandom % 200 == 0) do_reset();
      else step(rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
